// File: rtl/sort4_pkg.sv
// Shared types and constants for the sort4 stream loader and its fix-up compare-swap.
package sort4_pkg;

   parameter int SORT_W = 8;

   typedef enum logic [1:0] {
      FILL  = 2'd0,
      EVAL  = 2'd1,
      DRAIN = 2'd2
   } state_t;

   localparam logic [1:0] LAST_IDX = 2'd3;

endpackage

// File: rtl/sort4_minmax_swap.sv
// Two-input unsigned compare-swap: the larger operand leaves on o_hi, the smaller on o_lo.
module sort4_minmax_swap #(
   parameter int W = 8
) (
   input  logic [W-1:0] i_a,
   input  logic [W-1:0] i_b,
   output logic [W-1:0] o_hi,
   output logic [W-1:0] o_lo
);

   logic w_swap;

   assign w_swap = (i_a < i_b);
   assign o_hi   = w_swap ? i_b : i_a;
   assign o_lo   = w_swap ? i_a : i_b;

endmodule

// File: rtl/sort4_stream_loader.sv
// Collects four bytes for the external sorting network, then streams its results out largest first.
// Define SORT4_FIXUP_EN to order the network's middle pair so the output is fully descending.
module sort4_stream_loader
   import sort4_pkg::*;
#(
   parameter int W = SORT_W
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic [W-1:0] i_din,
   input  logic         i_din_valid,
   output logic         o_din_ready,
   output logic [W-1:0] o_n1,
   output logic [W-1:0] o_n2,
   output logic [W-1:0] o_n3,
   output logic [W-1:0] o_n4,
   input  logic [W-1:0] i_s1,
   input  logic [W-1:0] i_s2,
   input  logic [W-1:0] i_s3,
   input  logic [W-1:0] i_s4,
   output logic [W-1:0] o_dout,
   output logic         o_dout_valid,
   input  logic         i_dout_ready,
   output logic         o_dout_last
);

   state_t       r_state;
   state_t       w_next;
   logic [1:0]   r_idx;
   logic [1:0]   r_odx;
   logic [W-1:0] r_opnd [4];
   logic [W-1:0] r_res  [4];
   logic [W-1:0] w_midHi;
   logic [W-1:0] w_midLo;
   logic         w_inAcc;
   logic         w_outAcc;
   logic         w_lastIn;
   logic         w_lastOut;

   assign o_din_ready  = (r_state == FILL);
   assign o_dout_valid = (r_state == DRAIN);
   assign o_dout_last  = o_dout_valid & (r_odx == LAST_IDX);
   assign o_dout       = r_res[r_odx];
   assign w_inAcc      = i_din_valid & o_din_ready;
   assign w_outAcc     = o_dout_valid & i_dout_ready;
   assign w_lastIn     = w_inAcc & (r_idx == LAST_IDX);
   assign w_lastOut    = w_outAcc & (r_odx == LAST_IDX);

   assign o_n1 = r_opnd[0];
   assign o_n2 = r_opnd[1];
   assign o_n3 = r_opnd[2];
   assign o_n4 = r_opnd[3];

`ifdef SORT4_FIXUP_EN
   sort4_minmax_swap #(
      .W(W)
   ) u_midSwap (
      .i_a  (i_s2),
      .i_b  (i_s3),
      .o_hi (w_midHi),
      .o_lo (w_midLo)
   );
`else
   assign w_midHi = i_s2;
   assign w_midLo = i_s3;
`endif

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= FILL;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         FILL:    if (w_lastIn)  w_next = EVAL;
         EVAL:    w_next = DRAIN;
         DRAIN:   if (w_lastOut) w_next = FILL;
         default: w_next = FILL;
      endcase
   end

   // Operands only change on an accepted beat, so the network inputs stay put through EVAL and DRAIN.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_idx <= '0;
         for (int k = 0; k < 4; k++) begin
            r_opnd[k] <= '0;
         end
      end else if (r_state != FILL) begin
         r_idx <= '0;
      end else if (w_inAcc) begin
         r_opnd[r_idx] <= i_din;
         r_idx         <= r_idx + 2'd1;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_odx <= '0;
         for (int k = 0; k < 4; k++) begin
            r_res[k] <= '0;
         end
      end else begin
         if (r_state == EVAL) begin
            r_res[0] <= i_s1;
            r_res[1] <= w_midHi;
            r_res[2] <= w_midLo;
            r_res[3] <= i_s4;
         end
         if (r_state != DRAIN) begin
            r_odx <= '0;
         end else if (w_outAcc) begin
            r_odx <= r_odx + 2'd1;
         end
      end
   end

endmodule

// File: tb/tb_sort4_stream_loader.sv
// Self-checking bench for sort4_stream_loader; models the sorting network and compares against a queue-sort reference.
// Honours SORT4_FIXUP_EN the same way the design does.
module tb_sort4_stream_loader;

   typedef struct {
      logic [7:0] din [4];
      bit         midSwap;
      logic [7:0] exp [4];
   } vec_t;

   logic       clk = 1'b0;
   logic       rstN = 1'b0;
   logic [7:0] din = '0;
   logic       dinValid = 1'b0;
   logic       dinReady;
   logic [7:0] n1, n2, n3, n4;
   logic [7:0] s1, s2, s3, s4;
   logic [7:0] dout;
   logic       doutValid;
   logic       doutReady = 1'b1;
   logic       doutLast;
   bit         midSwap = 1'b0;

   int checks = 0;
   int errors = 0;

   vec_t vecs [5];

   always #5 clk = ~clk;

   sort4_stream_loader #(.W(8)) dut (
      .i_clk        (clk),
      .i_rst_n      (rstN),
      .i_din        (din),
      .i_din_valid  (dinValid),
      .o_din_ready  (dinReady),
      .o_n1         (n1),
      .o_n2         (n2),
      .o_n3         (n3),
      .o_n4         (n4),
      .i_s1         (s1),
      .i_s2         (s2),
      .i_s3         (s3),
      .i_s4         (s4),
      .o_dout       (dout),
      .o_dout_valid (doutValid),
      .i_dout_ready (doutReady),
      .o_dout_last  (doutLast)
   );

   // Stand-in for the sorting network; midSwap picks which middle value it presents on S2.
   always_comb begin
      logic [7:0] a [4];
      logic [7:0] t;
      t = '0;
      a[0] = n1; a[1] = n2; a[2] = n3; a[3] = n4;
      for (int p = 0; p < 3; p++) begin
         for (int j = 0; j < 3 - p; j++) begin
            if (a[j] < a[j+1]) begin
               t = a[j]; a[j] = a[j+1]; a[j+1] = t;
            end
         end
      end
      s1 = a[0];
      s4 = a[3];
      s2 = midSwap ? a[2] : a[1];
      s3 = midSwap ? a[1] : a[2];
   end

   function automatic void refModel(input logic [7:0] d [4], input bit ms, output logic [7:0] e [4]);
      logic [7:0] q [$];
      for (int i = 0; i < 4; i++) q.push_back(d[i]);
      q.rsort();
      for (int i = 0; i < 4; i++) e[i] = q[i];
`ifndef SORT4_FIXUP_EN
      if (ms) begin
         e[1] = q[2];
         e[2] = q[1];
      end
`endif
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic setVec(input int k, input logic [7:0] a, b, c, d, input bit ms,
                         input logic [7:0] e0, e1, e2, e3);
      vecs[k].din[0] = a;  vecs[k].din[1] = b;  vecs[k].din[2] = c;  vecs[k].din[3] = d;
      vecs[k].midSwap = ms;
      vecs[k].exp[0] = e0; vecs[k].exp[1] = e1; vecs[k].exp[2] = e2; vecs[k].exp[3] = e3;
   endtask

   // Offers one byte after `gap` idle cycles; returns just after the edge that accepted it.
   task automatic sendByte(input logic [7:0] b, input int gap);
      int guard;
      guard = 0;
      for (int g = 0; g < gap; g++) @(negedge clk);
      @(negedge clk);
      din = b;
      dinValid = 1'b1;
      while (!dinReady && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 50) check("dinReadyTimeout", {31'd0, dinReady}, 32'd1);
      @(posedge clk);
      #1;
      dinValid = 1'b0;
   endtask

   task automatic applyStimulus(input logic [7:0] d [4], input bit ms, input int gap);
      midSwap = ms;
      for (int i = 0; i < 4; i++) sendByte(d[i], gap);
   endtask

   // Called in the cycle after the fourth acceptance: expects EVAL there and R1 on the very next cycle.
   task automatic checkOutput(input string tag, input logic [7:0] d [4], input logic [7:0] e [4]);
      @(negedge clk);
      check({tag, ".evalDinReady"}, {31'd0, dinReady}, 32'd0);
      check({tag, ".evalDoutValid"}, {31'd0, doutValid}, 32'd0);
      check({tag, ".n1"}, {24'd0, n1}, {24'd0, d[0]});
      check({tag, ".n2"}, {24'd0, n2}, {24'd0, d[1]});
      check({tag, ".n3"}, {24'd0, n3}, {24'd0, d[2]});
      check({tag, ".n4"}, {24'd0, n4}, {24'd0, d[3]});
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check($sformatf("%s.valid%0d", tag, i), {31'd0, doutValid}, 32'd1);
         check($sformatf("%s.dout%0d", tag, i), {24'd0, dout}, {24'd0, e[i]});
         check($sformatf("%s.last%0d", tag, i), {31'd0, doutLast}, {31'd0, (i == 3)});
      end
      @(negedge clk);
      check({tag, ".backToFill"}, {31'd0, dinReady}, 32'd1);
   endtask

   initial begin
      logic [7:0] d [4];
      logic [7:0] e [4];

      setVec(0, 8'h10, 8'h40, 8'h20, 8'h30, 1'b0, 8'h40, 8'h30, 8'h20, 8'h10);
`ifdef SORT4_FIXUP_EN
      setVec(1, 8'h05, 8'h01, 8'h09, 8'h03, 1'b1, 8'h09, 8'h05, 8'h03, 8'h01);
      setVec(3, 8'h01, 8'h02, 8'h03, 8'h04, 1'b1, 8'h04, 8'h03, 8'h02, 8'h01);
`else
      setVec(1, 8'h05, 8'h01, 8'h09, 8'h03, 1'b1, 8'h09, 8'h03, 8'h05, 8'h01);
      setVec(3, 8'h01, 8'h02, 8'h03, 8'h04, 1'b1, 8'h04, 8'h02, 8'h03, 8'h01);
`endif
      setVec(2, 8'hFF, 8'h00, 8'hFF, 8'h00, 1'b0, 8'hFF, 8'hFF, 8'h00, 8'h00);
      setVec(4, 8'h7F, 8'h80, 8'h81, 8'h7E, 1'b0, 8'h81, 8'h80, 8'h7F, 8'h7E);

      // Values visible while reset is held.
      #1;
      check("rst.dinReady", {31'd0, dinReady}, 32'd1);
      check("rst.doutValid", {31'd0, doutValid}, 32'd0);
      check("rst.doutLast", {31'd0, doutLast}, 32'd0);
      check("rst.dout", {24'd0, dout}, 32'd0);
      check("rst.n1", {24'd0, n1}, 32'd0);
      repeat (2) @(negedge clk);
      rstN = 1'b1;

      for (int k = 0; k < 5; k++) begin
         applyStimulus(vecs[k].din, vecs[k].midSwap, 0);
         checkOutput($sformatf("vec%0d", k), vecs[k].din, vecs[k].exp);
      end

      // Gapped input: one beat every three cycles must give the back-to-back result.
      applyStimulus(vecs[0].din, vecs[0].midSwap, 2);
      checkOutput("gapped", vecs[0].din, vecs[0].exp);

      // Stall the last output beat for five cycles with a fifth byte waiting.
      d[0] = 8'h11; d[1] = 8'h22; d[2] = 8'h33; d[3] = 8'h44;
      applyStimulus(d, 1'b0, 0);
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check($sformatf("stall.dout%0d", i), {24'd0, dout}, {24'd0, 8'h44 - 8'(i) * 8'h11});
      end
      @(negedge clk);
      doutReady = 1'b0;
      din = 8'h55;
      dinValid = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("stall.dout", {24'd0, dout}, 32'h11);
         check("stall.last", {31'd0, doutLast}, 32'd1);
         check("stall.valid", {31'd0, doutValid}, 32'd1);
         check("stall.dinReady", {31'd0, dinReady}, 32'd0);
      end
      doutReady = 1'b1;
      @(negedge clk);
      check("stall.fillReady", {31'd0, dinReady}, 32'd1);
      check("stall.validDrop", {31'd0, doutValid}, 32'd0);
      check("stall.n1Held", {24'd0, n1}, 32'h11);
      @(posedge clk);
      #1;
      dinValid = 1'b0;
      @(negedge clk);
      check("stall.n1New", {24'd0, n1}, 32'h55);
      sendByte(8'h66, 0);
      sendByte(8'h77, 0);
      sendByte(8'h88, 0);
      d[0] = 8'h55; d[1] = 8'h66; d[2] = 8'h77; d[3] = 8'h88;
      e[0] = 8'h88; e[1] = 8'h77; e[2] = 8'h66; e[3] = 8'h55;
      checkOutput("afterStall", d, e);

      // Reset in the middle of a group discards the partial operands.
      sendByte(8'hAA, 0);
      sendByte(8'hBB, 0);
      @(negedge clk);
      rstN = 1'b0;
      #1;
      check("midRst.n1", {24'd0, n1}, 32'd0);
      check("midRst.n2", {24'd0, n2}, 32'd0);
      check("midRst.dinReady", {31'd0, dinReady}, 32'd1);
      check("midRst.dout", {24'd0, dout}, 32'd0);
      check("midRst.doutValid", {31'd0, doutValid}, 32'd0);
      @(negedge clk);
      rstN = 1'b1;
      d[0] = 8'h01; d[1] = 8'h02; d[2] = 8'h03; d[3] = 8'h04;
      e[0] = 8'h04; e[1] = 8'h03; e[2] = 8'h02; e[3] = 8'h01;
      applyStimulus(d, 1'b0, 0);
      checkOutput("postRst", d, e);

      // Random groups against the reference model, with ties favoured by a narrow value range.
      for (int r = 0; r < 20; r++) begin
         bit ms;
         for (int i = 0; i < 4; i++) begin
            d[i] = ($urandom_range(0, 1) == 1) ? 8'($urandom) : 8'($urandom_range(0, 3));
         end
         ms = 1'($urandom_range(0, 1));
         refModel(d, ms, e);
         applyStimulus(d, ms, int'($urandom_range(0, 2)));
         checkOutput($sformatf("rand%0d", r), d, e);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/sort4_stream_loader.md
# sort4_stream_loader

Streaming front/back end for the four-input 8-bit sorting network. It collects four bytes from a valid/ready input stream and holds them stable on the network inputs N1..N4. It then registers the network results S1..S4 and streams them out one byte per accepted beat, in descending order. It sits directly upstream of the network, feeding it, and directly downstream of it, consuming its results.

## Interface
- W, 8: data width; must match the network width.
- CLK  in  1  single clock; all state updates on the rising edge.
- RST_N  in  1  asynchronous, active-low reset; synchronous deassertion is provided by the top level.
- DIN  in  W  input byte.
- DIN_VALID  in  1  DIN is valid this cycle.
- DIN_READY  out  1  loader accepts DIN; a beat transfers when DIN_VALID & DIN_READY.
- N1, N2, N3, N4  out  W each  operands to the network, in arrival order: first byte on N1.
- S1, S2, S3, S4  in  W each  network results; S1 is the maximum, S4 the minimum, and S2/S3 are the middle pair in unspecified order.
- DOUT  out  W  output byte.
- DOUT_VALID  out  1  DOUT is valid.
- DOUT_READY  in  1  downstream accepts; a beat transfers when DOUT_VALID & DOUT_READY.
- DOUT_LAST  out  1  high with the fourth output beat of a group.

## Operation
- States:
  - FILL: DIN_READY=1; each accepted beat is written to operand slot idx, and idx increments.
  - EVAL: exactly one cycle; S1..S4 are captured into result registers R1..R4.
  - DRAIN: DOUT=R[odx]; odx advances on each transfer.
- Transitions:
  - FILL→EVAL on the accepted beat with idx==3.
  - EVAL→DRAIN unconditionally.
  - DRAIN→FILL on the transfer with odx==3.
- Slot index idx and output index odx are 2-bit counters. Both clear to 0 when the state is entered, so neither wraps implicitly.
- Operand registers N1..N4 are held unchanged from the EVAL cycle until the first FILL acceptance of the next group. The network is purely combinational and sees stable inputs for the whole EVAL cycle.
- DIN_READY is 0 in EVAL and DRAIN. Input arriving then is back-pressured, never dropped.
- DOUT_VALID=1 only in DRAIN. DOUT_LAST = DRAIN & (odx==3).
- DOUT is held stable while DOUT_VALID=1 and DOUT_READY=0.
- No arithmetic is performed except in the optional fix-up compare, which is an unsigned W-bit comparison.
- Equal values are legal. On a tie, the output order of the tied values is irrelevant because they are bit-identical.

## Timing
- Reset values: state=FILL, idx=0, odx=0, N1..N4=0, R1..R4=0, DIN_READY=1 one cycle... no: DIN_READY=1 immediately during reset (it is a combinational decode of state FILL). DOUT_VALID=0, DOUT_LAST=0, DOUT=0.
- Latency: the fourth input acceptance occurs at edge t. EVAL is active in cycle t+1. DOUT_VALID=1 in cycle t+2, carrying R1.
- Throughput: with no back-pressure, one group takes 4+1+4 = 9 cycles. Input and output never overlap.
- Reset asserted mid-group: the partial group is discarded and every register returns to its reset value asynchronously. The first beat after reset deassertion lands in N1.
- DIN_VALID may fall at any time during FILL. idx only advances on a transfer.

## Configuration
- SORT4_FIXUP_EN defined: in EVAL, if S2 < S3 then R2=S3 and R3=S2, otherwise R2=S2 and R3=S3. The output is fully descending.
- SORT4_FIXUP_EN undefined: R2=S2 and R3=S3 pass through unchanged. The middle pair keeps the network's order. Output ports and timing are identical in both builds.

## Structure
- Shared package sort4_pkg holds:
  - parameter SORT_W=8;
  - state enum {FILL, EVAL, DRAIN} as a 2-bit typedef;
  - localparam LAST_IDX=2'd3.
- One natural sub-module: sort4_minmax_swap, a two-input unsigned compare-swap with outputs hi/lo. It is instantiated only under SORT4_FIXUP_EN.
- The network itself is instantiated by the parent, not inside this block.

## Test plan
- Back-to-back input 0x10, 0x40, 0x20, 0x30 with DOUT_READY=1 → DOUT sequence 0x40, 0x30, 0x20, 0x10. DOUT_LAST is high on 0x10. The first output appears 2 cycles after the fourth acceptance.
- Input 0x05, 0x01, 0x09, 0x03, where the network yields middle pair S2=0x03, S3=0x05. With SORT4_FIXUP_EN → 0x09, 0x05, 0x03, 0x01. Without it → 0x09, 0x03, 0x05, 0x01.
- Input 0xFF, 0x00, 0xFF, 0x00 (ties and extremes) → 0xFF, 0xFF, 0x00, 0x00, with no signed misinterpretation.
- DOUT_READY held low for 5 cycles during DRAIN → DOUT and DOUT_LAST stay stable and DIN_READY stays 0. The 5th input beat is held off until the final output transfer completes.
- Reset pulsed after 2 inputs are accepted → all outputs return to reset values. The next 4 inputs 0x01..0x04 produce 0x04, 0x03, 0x02, 0x01.
- Gapped DIN_VALID (one beat every 3 cycles) → identical output to the back-to-back case. N1..N4 match arrival order during EVAL.
